// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller slice.
package alarm_pkg;
  localparam int TW      = 7;
  localparam int MIN_MOD = 60;
  localparam int HRS_MOD = 24;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RINGING,
    SNOOZING
  } state_t;
endpackage

// File: rtl/alarm_wrap_ctr.sv
// Modulo-N up counter with enable and synchronous reset; holds an alarm setpoint field.
module alarm_wrap_ctr #(
  parameter int N = 60,
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= (q == W'(N - 1)) ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: setpoint registers, arm/ring/snooze sequencing and timed buzz.
// Build option: define ALARM_SNOOZE_EN to enable the SNOOZING state; otherwise snooze dismisses the ring.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_CYCLES = 60,
  parameter int SNOOZE_MIN  = 9
) (
  input  logic          Pulse,
  input  logic          Reset,
  input  logic [TW-1:0] tmin,
  input  logic [TW-1:0] thrs,
  input  logic          alarmset,
  input  logic          minadv,
  input  logic          hrsadv,
  input  logic          alarmon,
  input  logic          snooze,
  output logic [TW-1:0] amin,
  output logic [TW-1:0] ahrs,
  output logic          buzz,
  output logic          snoozing
);

  localparam int CW = $clog2(RING_CYCLES + 1);

  if (RING_CYCLES < 1 || SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_param_check
    $error("alarm_ctrl: RING_CYCLES or SNOOZE_MIN out of range");
  end

  state_t          state, state_nxt;
  logic [CW-1:0]   ring_cnt, ring_cnt_nxt;
  logic            match, match_q, trigger;

  alarm_wrap_ctr #(.N(MIN_MOD), .W(TW)) u_amin (
    .clk (Pulse),
    .rst (Reset),
    .en  (alarmset & minadv),
    .q   (amin)
  );

  alarm_wrap_ctr #(.N(HRS_MOD), .W(TW)) u_ahrs (
    .clk (Pulse),
    .rst (Reset),
    .en  (alarmset & hrsadv),
    .q   (ahrs)
  );

  // Ring only on the cycle time first equals the setpoint, never on a held match.
  assign match   = (tmin == amin) && (thrs == ahrs);
  assign trigger = match & ~match_q;

`ifdef ALARM_SNOOZE_EN
  logic [TW-1:0] tgt_min, tgt_hrs;
  logic          capture;

  function automatic logic [2*TW-1:0] add_snooze(input logic [TW-1:0] m, input logic [TW-1:0] h);
    logic [TW-1:0] mm;
    logic [TW-1:0] hh;
    mm = m + TW'(SNOOZE_MIN);
    hh = h;
    if (mm >= TW'(MIN_MOD)) begin
      mm = mm - TW'(MIN_MOD);
      hh = (h == TW'(HRS_MOD - 1)) ? '0 : h + TW'(1);
    end
    return {hh, mm};
  endfunction

  always_ff @(posedge Pulse) begin
    if (Reset) begin
      tgt_min <= '0;
      tgt_hrs <= '0;
    end else if (capture) begin
      {tgt_hrs, tgt_min} <= add_snooze(tmin, thrs);
    end
  end
`endif

  always_ff @(posedge Pulse) begin
    if (Reset) begin
      state    <= IDLE;
      ring_cnt <= '0;
      match_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ring_cnt <= ring_cnt_nxt;
      match_q  <= match;
    end
  end

  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = '0;
`ifdef ALARM_SNOOZE_EN
    capture      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (alarmon) state_nxt = ARMED;
      end
      ARMED: begin
        if (!alarmon)                  state_nxt = IDLE;
        else if (trigger && !alarmset) state_nxt = RINGING;
      end
      RINGING: begin
        if (!alarmon)      state_nxt = IDLE;
        else if (alarmset) state_nxt = ARMED;
        else if (snooze) begin
`ifdef ALARM_SNOOZE_EN
          state_nxt = SNOOZING;
          capture   = 1'b1;
`else
          state_nxt = ARMED;
`endif
        end
        else if (ring_cnt == CW'(RING_CYCLES - 1)) state_nxt = ARMED;
        else ring_cnt_nxt = ring_cnt + CW'(1);
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZING: begin
        if (!alarmon)      state_nxt = IDLE;
        else if (alarmset) state_nxt = ARMED;
        else if (tmin == tgt_min && thrs == tgt_hrs) state_nxt = RINGING;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign buzz = (state == RINGING);
`ifdef ALARM_SNOOZE_EN
  assign snoozing = (state == SNOOZING);
`else
  assign snoozing = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl with RING_CYCLES=4, SNOOZE_MIN=9.
module tb_alarm_ctrl;
  import alarm_pkg::*;

  logic          Pulse = 1'b0;
  logic          Reset;
  logic [TW-1:0] tmin, thrs;
  logic          alarmset, minadv, hrsadv, alarmon, snooze;
  logic [TW-1:0] amin, ahrs;
  logic          buzz, snoozing;

  int total = 0;
  int bad   = 0;

  alarm_ctrl #(.RING_CYCLES(4), .SNOOZE_MIN(9)) dut (
    .Pulse    (Pulse),
    .Reset    (Reset),
    .tmin     (tmin),
    .thrs     (thrs),
    .alarmset (alarmset),
    .minadv   (minadv),
    .hrsadv   (hrsadv),
    .alarmon  (alarmon),
    .snooze   (snooze),
    .amin     (amin),
    .ahrs     (ahrs),
    .buzz     (buzz),
    .snoozing (snoozing)
  );

  always #5 Pulse = ~Pulse;

  task automatic step(input int n);
    repeat (n) @(posedge Pulse);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; tmin = '0; thrs = '0;
    alarmset = 1'b0; minadv = 1'b0; hrsadv = 1'b0; alarmon = 1'b0; snooze = 1'b0;
    step(2);
    chk("rst_amin", 32'(amin), 0);
    chk("rst_ahrs", 32'(ahrs), 0);
    chk("rst_buzz", 32'(buzz), 0);
    chk("rst_snoozing", 32'(snoozing), 0);
    Reset = 1'b0;

    // Setpoint editing and wrap boundaries
    alarmset = 1'b1;
    hrsadv = 1'b1; step(7); hrsadv = 1'b0;
    minadv = 1'b1; step(30); minadv = 1'b0;
    chk("set_ahrs7", 32'(ahrs), 7);
    chk("set_amin30", 32'(amin), 30);
    minadv = 1'b1; step(29);
    chk("amin59", 32'(amin), 59);
    step(1);
    chk("amin_wrap", 32'(amin), 0);
    chk("amin_wrap_nocarry", 32'(ahrs), 7);
    step(30); minadv = 1'b0;
    chk("amin_back30", 32'(amin), 30);
    hrsadv = 1'b1; minadv = 1'b1; step(1); minadv = 1'b0;
    chk("both_amin", 32'(amin), 31);
    chk("both_ahrs", 32'(ahrs), 8);
    step(15);
    chk("ahrs23", 32'(ahrs), 23);
    step(1);
    chk("ahrs_wrap", 32'(ahrs), 0);
    step(7); hrsadv = 1'b0;
    minadv = 1'b1; step(59); minadv = 1'b0;
    chk("restore_ahrs", 32'(ahrs), 7);
    chk("restore_amin", 32'(amin), 30);
    alarmset = 1'b0;

    // First ring at 7:30, exactly four cycles
    tmin = 29; thrs = 7; alarmon = 1'b1;
    step(2);
    chk("armed_quiet", 32'(buzz), 0);
    tmin = 30;
    chk("no_comb_path", 32'(buzz), 0);
    step(1);
    chk("ring_c1", 32'(buzz), 1);
    for (int i = 2; i <= 4; i++) begin
      step(1);
      chk($sformatf("ring_c%0d", i), 32'(buzz), 1);
    end
    step(1);
    chk("ring_end", 32'(buzz), 0);
    step(3);
    chk("no_retrig", 32'(buzz), 0);

    // Snooze at 7:30
    tmin = 29; step(1); tmin = 30; step(1);
    chk("ring2", 32'(buzz), 1);
    snooze = 1'b1; step(1); snooze = 1'b0;
    chk("snz_buzz_off", 32'(buzz), 0);
`ifdef ALARM_SNOOZE_EN
    chk("snz_on", 32'(snoozing), 1);
    tmin = 38; step(2);
    chk("snz_wait_buzz", 32'(buzz), 0);
    chk("snz_wait_state", 32'(snoozing), 1);
    tmin = 39; step(1);
    chk("rering_739", 32'(buzz), 1);
    chk("rering_snz_off", 32'(snoozing), 0);
    step(3);
    chk("rering_hold", 32'(buzz), 1);
    step(1);
    chk("rering_end", 32'(buzz), 0);
`else
    chk("dismiss_snz", 32'(snoozing), 0);
    tmin = 38; step(2);
    chk("dismiss_quiet", 32'(buzz), 0);
    tmin = 39; step(1);
    chk("no_rering_739", 32'(buzz), 0);
    step(4);
`endif

    // alarmon drop during ring, then enable while already matching
    tmin = 29; step(1); tmin = 30; step(1);
    chk("ring3", 32'(buzz), 1);
    alarmon = 1'b0; step(1);
    chk("off_buzz", 32'(buzz), 0);
    step(1);
    alarmon = 1'b1; step(3);
    chk("on_at_match", 32'(buzz), 0);

    // Edit setpoint onto current time 23:55 while armed
    tmin = 55; thrs = 23;
    alarmset = 1'b1;
    hrsadv = 1'b1; step(16); hrsadv = 1'b0;
    chk("edit_ahrs23", 32'(ahrs), 23);
    minadv = 1'b1; step(25); minadv = 1'b0;
    chk("edit_amin55", 32'(amin), 55);
    step(1);
    chk("edit_onto_time", 32'(buzz), 0);
    alarmset = 1'b0; step(3);
    chk("release_set", 32'(buzz), 0);

    // Ring at 23:55 and snooze across midnight
    tmin = 54; step(1); tmin = 55; step(1);
    chk("ring_2355", 32'(buzz), 1);
    snooze = 1'b1; step(1); snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
    chk("snz2_on", 32'(snoozing), 1);
    thrs = 0; tmin = 3; step(2);
    chk("snz2_wait", 32'(buzz), 0);
    tmin = 4; step(1);
    chk("ring_0004", 32'(buzz), 1);
    step(4);
    chk("ring_0004_end", 32'(buzz), 0);
`else
    chk("snz2_off", 32'(snoozing), 0);
    chk("snz2_buzz", 32'(buzz), 0);
    thrs = 0; tmin = 3; step(2);
    tmin = 4; step(1);
    chk("no_ring_0004", 32'(buzz), 0);
    step(4);
`endif

    // Reset in the middle of a ring
    thrs = 23; tmin = 54; step(1); tmin = 55; step(1);
    chk("ring_pre_rst", 32'(buzz), 1);
    step(1);
    Reset = 1'b1; step(1);
    chk("midrst_buzz", 32'(buzz), 0);
    chk("midrst_snoozing", 32'(snoozing), 0);
    chk("midrst_amin", 32'(amin), 0);
    chk("midrst_ahrs", 32'(ahrs), 0);
    Reset = 1'b0; step(3);
    chk("post_rst_quiet", 32'(buzz), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
